// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed byte-stream image and writes little-endian 32-bit words into instruction memory.
// Write latency is 1 cycle after the 4th byte of a word; in_ready is low in DONE/ERR, and the core is held in reset until the checksum passes.
module imem_boot_loader #(
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int              MAX_WORDS = 1 << ADDR_W;
    localparam int              TW        = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_CLO  = 3'd0,
        S_CHI  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t            r_state;
    logic [7:0]        r_cnt_lo;
    logic [ADDR_W:0]   r_words_left;
    logic [1:0]        r_lane;
    logic [23:0]       r_word;
    logic [7:0]        r_csum;
    logic [TW-1:0]     r_timer;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_hold;
    logic              r_done;
    logic              r_error;
    logic [1:0]        r_err_code;

    logic              w_accept;
    logic              w_timed;
    logic              w_timeout;
    logic [15:0]       w_count;
    logic              w_count_bad;

    always_comb begin
        in_ready = (r_state == S_CLO) || (r_state == S_CHI) ||
                   (r_state == S_DATA) || (r_state == S_CSUM);
    end

    assign w_accept    = in_valid & in_ready;
    assign w_timed     = (r_state == S_CHI) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_timeout   = w_timed && !w_accept && (r_timer == TMO_LAST);
    assign w_count     = {in_data, r_cnt_lo};
    assign w_count_bad = (w_count == 16'd0) || (int'(w_count) > MAX_WORDS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_CLO;
            r_cnt_lo     <= '0;
            r_words_left <= '0;
            r_lane       <= '0;
            r_word       <= '0;
            r_csum       <= '0;
            r_timer      <= '0;
            r_we         <= 1'b0;
            r_addr       <= BASE_ADDR;
            r_wdata      <= '0;
            r_hold       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= 2'd0;
        end else begin
            r_we <= 1'b0;
            // Address advances in the cycle after each write strobe, wrapping naturally.
            if (r_we) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_timed) begin
                if (w_accept) begin
                    r_timer <= '0;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end

            case (r_state)
                S_CLO: begin
                    if (w_accept) begin
                        r_cnt_lo <= in_data;
                        r_csum   <= in_data;
                        r_state  <= S_CHI;
                    end
                end
                S_CHI: begin
                    if (w_accept) begin
                        r_csum <= r_csum ^ in_data;
                        if (w_count_bad) begin
                            r_state    <= S_ERR;
                            r_error    <= 1'b1;
                            r_err_code <= 2'd1;
                        end else begin
                            r_words_left <= (ADDR_W+1)'(w_count);
                            r_lane       <= 2'd0;
                            r_state      <= S_DATA;
                        end
                    end else if (w_timeout) begin
                        r_state    <= S_ERR;
                        r_error    <= 1'b1;
                        r_err_code <= 2'd3;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_csum <= r_csum ^ in_data;
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0: r_word[7:0]   <= in_data;
                            2'd1: r_word[15:8]  <= in_data;
                            2'd2: r_word[23:16] <= in_data;
                            default: begin
                                r_we         <= 1'b1;
                                r_wdata      <= {in_data, r_word};
                                r_words_left <= r_words_left - 1'b1;
                                if (r_words_left == (ADDR_W+1)'(1)) begin
                                    r_state <= S_CSUM;
                                end
                            end
                        endcase
                    end else if (w_timeout) begin
                        r_state    <= S_ERR;
                        r_error    <= 1'b1;
                        r_err_code <= 2'd3;
                    end
                end
                S_CSUM: begin
                    if (w_accept) begin
                        if (in_data == r_csum) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state    <= S_ERR;
                            r_error    <= 1'b1;
                            r_err_code <= 2'd2;
                        end
                    end else if (w_timeout) begin
                        r_state    <= S_ERR;
                        r_error    <= 1'b1;
                        r_err_code <= 2'd3;
                    end
                end
                S_DONE, S_ERR: begin
                    // Any partially written image is left in memory on re-arm.
                    if (start) begin
                        r_state    <= S_CLO;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_err_code <= 2'd0;
                        r_csum     <= '0;
                        r_timer    <= '0;
                        r_hold     <= 1'b1;
                        r_addr     <= BASE_ADDR;
                    end
                end
                default: r_state <= S_CLO;
            endcase
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = r_hold;
    assign done       = r_done;
    assign error      = r_error;
    assign err_code   = r_err_code;

endmodule
